// File: rtl/param_updown_counter.sv
// Loadable up/down counter with programmable upper terminal, saturate/wrap modes and a
// registered terminal pulse. Optional sticky overflow flag is enabled by CNT_STICKY_OVF_EN.
module param_updown_counter #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_cnt,
    input  logic             cnt,
    input  logic             up,
    input  logic             wrap,
    input  logic [WIDTH-1:0] init0,
    input  logic [WIDTH-1:0] lim,
`ifdef CNT_STICKY_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] parout,
    output logic             co,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] parout_reg;
    logic [WIDTH-1:0] parout_next;
    logic             tc_reg;
    logic             tc_next;

    // Up mode treats anything at or above lim as terminal, so a count loaded above lim
    // saturates or wraps instead of running on to the modulo rollover.
    assign co = up ? (parout_reg >= lim) : (parout_reg == '0);

    always_comb begin
        parout_next = parout_reg;
        tc_next     = 1'b0;
        if (ld_cnt) begin
            parout_next = init0;
        end else if (cnt) begin
            if (!co) begin
                parout_next = up ? (parout_reg + ONE) : (parout_reg - ONE);
            end else begin
                tc_next = 1'b1;
                if (wrap) begin
                    parout_next = up ? '0 : lim;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parout_reg <= RST_VAL;
            tc_reg     <= 1'b0;
        end else begin
            parout_reg <= parout_next;
            tc_reg     <= tc_next;
        end
    end

`ifdef CNT_STICKY_OVF_EN
    logic ovf_sticky_reg;

    // Clear has priority over a coincident terminal event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky_reg <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky_reg <= 1'b0;
        end else if (tc_next) begin
            ovf_sticky_reg <= 1'b1;
        end
    end

    assign ovf_sticky = ovf_sticky_reg;
`endif

    assign parout = parout_reg;
    assign tc     = tc_reg;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=3, RST_VAL=0): directed scenarios
// plus randomized stimulus against a behavioural model of the counting rules.
module tb_param_updown_counter;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_cnt;
    logic         cnt;
    logic         up;
    logic         wrap;
    logic [W-1:0] init0;
    logic [W-1:0] lim;
    logic [W-1:0] parout;
    logic         co;
    logic         tc;
`ifdef CNT_STICKY_OVF_EN
    logic         ovf_clr;
    logic         ovf_sticky;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    int m_cnt;
    bit m_tc;
    bit m_ovf;

    param_updown_counter #(
        .WIDTH   (W),
        .RST_VAL (3'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_cnt     (ld_cnt),
        .cnt        (cnt),
        .up         (up),
        .wrap       (wrap),
        .init0      (init0),
        .lim        (lim),
`ifdef CNT_STICKY_OVF_EN
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`endif
        .parout     (parout),
        .co         (co),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit l, input bit c, input bit u, input bit w,
                         input int i, input int li);
        ld_cnt = l;
        cnt    = c;
        up     = u;
        wrap   = w;
        init0  = i[W-1:0];
        lim    = li[W-1:0];
    endtask

    function automatic bit model_co();
        if (up) return (m_cnt >= int'(lim));
        return (m_cnt == 0);
    endfunction

    // One clock: predict from the live inputs, step past the edge, sample at the falling edge.
    task automatic tick();
        int n;
        bit t;
        bit o;
        n = m_cnt;
        t = 1'b0;
        o = m_ovf;
        if (!rst) begin
            n = 0;
            o = 1'b0;
        end else if (ld_cnt) begin
            n = int'(init0);
        end else if (cnt) begin
            if (!model_co()) begin
                n = up ? m_cnt + 1 : m_cnt - 1;
            end else begin
                t = 1'b1;
                if (wrap) n = up ? 0 : int'(lim);
            end
        end
`ifdef CNT_STICKY_OVF_EN
        if (rst) begin
            if (ovf_clr) o = 1'b0;
            else if (t)  o = 1'b1;
        end
`endif
        @(posedge clk);
        @(negedge clk);
        m_cnt = n;
        m_tc  = t;
        m_ovf = o;
        $display("txn rst=%0b ld=%0b cnt=%0b up=%0b wrap=%0b init0=%0d lim=%0d -> parout=%0d co=%0b tc=%0b",
                 rst, ld_cnt, cnt, up, wrap, init0, lim, parout, co, tc);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_tc  = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (parout !== 3'd0 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: parout=%0d tc=%0b, required parout=0 tc=0", parout, tc);
        end
        rst = 1'b1;
        drive(1, 0, 1, 0, 2, 5);
        tick();
        drive(0, 1, 1, 0, 0, 5);
        repeat (4) tick();
        vectors++;
        if (parout !== 3'd5 || tc !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_precount: parout=%0d tc=%0b, required parout=5 tc=1", parout, tc);
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (parout !== 3'd0 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: parout=%0d tc=%0b, required parout=0 tc=0", parout, tc);
        end
        tick();
        vectors++;
        if (parout !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_hold: parout=%0d, required 0", parout);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (parout !== 3'd1 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_resume: parout=%0d tc=%0b, required parout=1 tc=0", parout, tc);
        end
    endtask

    task automatic test_saturate();
        int ep[6];
        int et[6];
        int ec[6];
        ep = '{3, 4, 5, 5, 5, 5};
        et = '{0, 0, 0, 1, 1, 1};
        ec = '{0, 0, 1, 1, 1, 1};
        drive(1, 0, 1, 0, 2, 5);
        tick();
        drive(0, 1, 1, 0, 0, 5);
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (parout !== ep[k][W-1:0] || tc !== et[k][0] || co !== ec[k][0]) begin
                miscompares++;
                $display("FAIL saturate[%0d]: parout=%0d co=%0b tc=%0b, required parout=%0d co=%0d tc=%0d",
                         k, parout, co, tc, ep[k], ec[k], et[k]);
            end
        end
    endtask

    task automatic test_wrap_up();
        int ep[3];
        int et[3];
        ep = '{6, 0, 1};
        et = '{0, 1, 0};
        drive(1, 0, 1, 1, 5, 6);
        tick();
        drive(0, 1, 1, 1, 0, 6);
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (parout !== ep[k][W-1:0] || tc !== et[k][0]) begin
                miscompares++;
                $display("FAIL wrap_up[%0d]: parout=%0d tc=%0b, required parout=%0d tc=%0d",
                         k, parout, tc, ep[k], et[k]);
            end
        end
    endtask

    task automatic test_wrap_down();
        int ep[3];
        int et[3];
        ep = '{0, 4, 3};
        et = '{0, 1, 0};
        drive(1, 0, 0, 1, 1, 4);
        tick();
        drive(0, 1, 0, 1, 0, 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (parout !== ep[k][W-1:0] || tc !== et[k][0]) begin
                miscompares++;
                $display("FAIL wrap_down[%0d]: parout=%0d tc=%0b, required parout=%0d tc=%0d",
                         k, parout, tc, ep[k], et[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        drive(1, 0, 0, 0, 0, 5);
        tick();
        drive(0, 1, 0, 0, 0, 5);
        tick();
        vectors++;
        if (tc !== 1'b1) begin
            miscompares++;
            $display("FAIL load_pre_tc: tc=%0b, required 1", tc);
        end
        drive(1, 1, 1, 0, 7, 5);
        tick();
        vectors++;
        if (parout !== 3'd7 || tc !== 1'b0) begin
            miscompares++;
            $display("FAIL load_wins: parout=%0d tc=%0b, required parout=7 tc=0", parout, tc);
        end
        drive(0, 0, 1, 0, 0, 3);
        #1;
        vectors++;
        if (co !== 1'b1) begin
            miscompares++;
            $display("FAIL above_lim_co: co=%0b, required 1", co);
        end
        drive(0, 1, 1, 0, 0, 3);
        tick();
        vectors++;
        if (parout !== 3'd7 || tc !== 1'b1) begin
            miscompares++;
            $display("FAIL above_lim_hold: parout=%0d tc=%0b, required parout=7 tc=1", parout, tc);
        end
        drive(0, 1, 1, 1, 0, 0);
        tick();
        vectors++;
        if (parout !== 3'd0 || tc !== 1'b1) begin
            miscompares++;
            $display("FAIL lim0_wrap: parout=%0d tc=%0b, required parout=0 tc=1", parout, tc);
        end
    endtask

`ifdef CNT_STICKY_OVF_EN
    task automatic test_sticky();
        ovf_clr = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL sticky_reset: ovf_sticky=%0b, required 0", ovf_sticky);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 1, 0, 4, 5);
        tick();
        drive(0, 1, 1, 0, 0, 5);
        tick();
        vectors++;
        if (ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL sticky_early: ovf_sticky=%0b, required 0", ovf_sticky);
        end
        tick();
        vectors++;
        if (ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_set: ovf_sticky=%0b, required 1", ovf_sticky);
        end
        drive(0, 1, 0, 0, 0, 5);
        repeat (2) tick();
        vectors++;
        if (parout !== 3'd3 || ovf_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_hold: parout=%0d ovf_sticky=%0b, required parout=3 ovf_sticky=1",
                     parout, ovf_sticky);
        end
        drive(0, 1, 1, 0, 0, 3);
        ovf_clr = 1'b1;
        tick();
        vectors++;
        if (tc !== 1'b1 || ovf_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL sticky_clr_wins: tc=%0b ovf_sticky=%0b, required tc=1 ovf_sticky=0",
                     tc, ovf_sticky);
        end
        ovf_clr = 1'b0;
    endtask
`endif

    task automatic test_random();
        bit l, c, u, w;
        int i, li;
        u  = 1'b1;
        w  = 1'b0;
        li = 5;
        for (int n = 0; n < 400; n++) begin
            l = ($urandom_range(0, 9) == 0);
            c = ($urandom_range(0, 3) != 0);
            i = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) u  = ~u;
            if ($urandom_range(0, 7) == 0) w  = ~w;
            if ($urandom_range(0, 7) == 0) li = $urandom_range(0, 7);
            drive(l, c, u, w, i, li);
`ifdef CNT_STICKY_OVF_EN
            ovf_clr = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b0;
                model_reset();
            end
            #1;
            vectors++;
            if (co !== model_co()) begin
                miscompares++;
                $display("FAIL rand_co[%0d]: co=%0b, required %0b", n, co, model_co());
            end
            tick();
            rst = 1'b1;
            vectors++;
            if (parout !== m_cnt[W-1:0] || tc !== m_tc) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: parout=%0d tc=%0b, required parout=%0d tc=%0b",
                         n, parout, tc, m_cnt, m_tc);
            end
`ifdef CNT_STICKY_OVF_EN
            vectors++;
            if (ovf_sticky !== m_ovf) begin
                miscompares++;
                $display("FAIL rand_ovf[%0d]: ovf_sticky=%0b, required %0b", n, ovf_sticky, m_ovf);
            end
`endif
        end
`ifdef CNT_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef CNT_STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        model_reset();
        test_reset();
        test_saturate();
        test_wrap_up();
        test_wrap_down();
        test_load_priority();
`ifdef CNT_STICKY_OVF_EN
        test_sticky();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
